// File: rtl/tick_arbiter.sv
// Arbitrates a shared skip-counted tick generator among NREQ requesters; each grant gets a BURST of ticks.
// Define TICK_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module tick_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned W     = 32,
   parameter int unsigned BURST = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] skip,
   output logic [NREQ-1:0]   gnt,
   output logic              tick,
   output logic [3:0]        tick_cnt,
   output logic              busy,
   output logic              done
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_t;

   state_t        state;
   logic [IW-1:0] win_q;
   logic [W-1:0]  skip_q;
   logic [W-1:0]  divider;
   logic [W-1:0]  skip_sel;

   logic [IW-1:0] start;
   logic [IW-1:0] cand;
   logic [IW-1:0] pick_idx;
   logic          pick_found;

`ifdef TICK_ARB_FIXED_PRIO_EN
   assign start = '0;
`else
   logic [IW-1:0] rr_ptr;

   // Round-robin pointer moves just past the winner when its grant is released
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr <= '0;
      end else if (state == RELEASE) begin
         rr_ptr <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
      end
   end

   assign start = rr_ptr;
`endif

   // First requesting index at or after start, wrapping modulo NREQ
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int off = 0; off < int'(NREQ); off++) begin
         cand = IW'((int'(start) + off) % int'(NREQ));
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign skip_sel = skip[int'(win_q)*W +: W];

   // Grant/burst sequencer; outputs are cleared on the way into RELEASE so the grant gap is two cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         gnt      <= '0;
         tick     <= 1'b0;
         tick_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         divider  <= '0;
         skip_q   <= '0;
         win_q    <= '0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  win_q <= pick_idx;
                  gnt   <= NREQ'(1) << pick_idx;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               skip_q   <= skip_sel;
               divider  <= '0;
               tick_cnt <= '0;
               state    <= RUN;
            end
            RUN: begin
               // A completed burst takes precedence over a request dropped in the same cycle
               if (tick_cnt == 4'(BURST)) begin
                  done     <= 1'b1;
                  gnt      <= '0;
                  tick_cnt <= '0;
                  state    <= RELEASE;
               end else if (!req[win_q]) begin
                  gnt      <= '0;
                  tick_cnt <= '0;
                  state    <= RELEASE;
               end else if (divider == skip_q) begin
                  divider  <= '0;
                  tick     <= 1'b1;
                  tick_cnt <= tick_cnt + 4'd1;
               end else begin
                  divider  <= divider + W'(1);
               end
            end
            RELEASE: begin
               gnt      <= '0;
               tick_cnt <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tick_arbiter.sv
// Self-checking bench for tick_arbiter: scenario table, directed corner sequences and a
// randomized run compared every cycle against a timeline-based reference model.
module tb_tick_arbiter;

   localparam int NREQ  = 4;
   localparam int W     = 32;
   localparam int BURST = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] skip;
   logic [NREQ-1:0]   gnt;
   logic              tick;
   logic [3:0]        tick_cnt;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   tick_arbiter #(.NREQ(NREQ), .W(W), .BURST(BURST)) dut (
      .clk(clk), .rst(rst), .req(req), .skip(skip),
      .gnt(gnt), .tick(tick), .tick_cnt(tick_cnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each grant is a timeline measured in edges since the grant edge.
   // Edge 1 latches skip s; tick k (1..BURST) lands on edge 1+k*(s+1); done on edge 2+BURST*(s+1).
   logic [3:0] m_gnt;
   bit         m_tick, m_busy, m_done, m_act, m_rel;
   int         m_cnt, m_r, m_w, m_rr;
   longint     m_s, m_k;

   task automatic m_finish(input bit full);
      m_done = full;
      m_gnt  = '0;
      m_tick = 1'b0;
      m_cnt  = 0;
      m_act  = 1'b0;
      m_rel  = 1'b1;
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         m_act = 0; m_rel = 0; m_rr = 0;
         m_gnt = '0; m_tick = 0; m_cnt = 0; m_busy = 0; m_done = 0;
      end else if (m_rel) begin
         m_rel  = 0;
         m_busy = 0;
         m_done = 0;
`ifndef TICK_ARB_FIXED_PRIO_EN
         m_rr = (m_w + 1) % NREQ;
`endif
      end else if (m_act) begin
         m_r++;
         m_tick = 0;
         if (m_r == 1) begin
            m_s = longint'(skip[m_w*W +: W]);
         end else if (longint'(m_r) == 2 + BURST*(m_s + 1)) begin
            m_finish(1'b1);
         end else if (!req[m_w]) begin
            m_finish(1'b0);
         end else begin
            m_k    = longint'(m_r - 1);
            m_tick = (m_k % (m_s + 1)) == 0;
            m_cnt  = int'(m_k / (m_s + 1));
         end
      end else if (req != 0) begin
         m_w = -1;
         for (int o = 0; o < NREQ; o++) begin
            if (m_w < 0 && req[(m_rr + o) % NREQ]) m_w = (m_rr + o) % NREQ;
         end
         m_act  = 1;
         m_r    = 0;
         m_gnt  = 4'(1 << m_w);
         m_busy = 1;
         m_tick = 0;
         m_done = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_gnt",  32'(gnt),      32'(m_gnt));
         chk("model_tick", 32'(tick),     32'(m_tick));
         chk("model_cnt",  32'(tick_cnt), 32'(m_cnt));
         chk("model_busy", 32'(busy),     32'(m_busy));
         chk("model_done", 32'(done),     32'(m_done));
      end
   end

   typedef struct {
      logic [3:0] req;
      int         skip;
      int         drop;      // drop req after this many ticks, 0 = hold
      logic [3:0] exp_gnt;
      int         exp_ticks;
      int         exp_dones;
   } scen_t;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic set_skip_all(input int v);
      for (int i = 0; i < NREQ; i++) skip[i*W +: W] = W'(v);
   endtask

   scen_t      sc [6];
   logic [3:0] got [5];
   logic [3:0] exp_order [5];
   logic [3:0] prev;
   int ticks, dones, cyc, last_tick, n;
   bit spacing_ok, seen_busy, first, saw_done, abort_seen, hit;

   initial begin
      sc[0] = '{4'b0100, 3, 0, 4'b0100, 8, 1};
      sc[1] = '{4'b0001, 0, 0, 4'b0001, 8, 1};
      sc[2] = '{4'b1010, 1, 0, 4'b0010, 8, 1};
      sc[3] = '{4'b0010, 2, 3, 4'b0010, 3, 0};
      sc[4] = '{4'b1000, 5, 0, 4'b1000, 8, 1};
      sc[5] = '{4'b1111, 0, 7, 4'b0001, 7, 0};
`ifdef TICK_ARB_FIXED_PRIO_EN
      exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

      // Reset held two edges with all requests active
      rst = 1'b0;
      req = 4'b1111;
      skip = '0;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_gnt",  32'(gnt),      32'h0);
      chk("rst_tick", 32'(tick),     32'h0);
      chk("rst_cnt",  32'(tick_cnt), 32'h0);
      chk("rst_busy", 32'(busy),     32'h0);
      chk("rst_done", 32'(done),     32'h0);
      rst = 1'b1;
      req = '0;

      for (int i = 0; i < 6; i++) begin
         do_reset();
         set_skip_all(sc[i].skip);
         req = sc[i].req;
         ticks = 0; dones = 0; cyc = 0; last_tick = -1;
         spacing_ok = 1; seen_busy = 0; first = 1;
         while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (first) begin
               chk("scen_gnt", 32'(gnt), 32'(sc[i].exp_gnt));
               first = 0;
            end
            if (busy) seen_busy = 1;
            if (tick) begin
               if (last_tick >= 0 && cyc - last_tick != sc[i].skip + 1) spacing_ok = 0;
               last_tick = cyc;
               ticks++;
            end
            if (done) dones++;
            if (seen_busy && !busy) break;
            if (sc[i].drop != 0 && ticks == sc[i].drop) req = '0;
         end
         req = '0;
         chk("scen_timeout", 32'(cyc < 400), 32'h1);
         chk("scen_ticks",   32'(ticks),     32'(sc[i].exp_ticks));
         chk("scen_done",    32'(dones),     32'(sc[i].exp_dones));
         chk("scen_spacing", 32'(spacing_ok), 32'h1);
      end

      // Grant order with every requester held
      do_reset();
      set_skip_all(0);
      req = 4'b1111;
      prev = '0; n = 0; cyc = 0;
      for (int k = 0; k < 5; k++) got[k] = '0;
      while (n < 5 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (gnt != 0 && prev == 0) begin
            got[n] = gnt;
            n++;
         end
         prev = gnt;
      end
      req = '0;
      for (int k = 0; k < 5; k++) chk("grant_order", 32'(got[k]), 32'(exp_order[k]));

      // Abort after three ticks, waiting requester takes over
      do_reset();
      set_skip_all(0);
      skip[1*W +: W] = W'(2);
      req = 4'b1010;
      ticks = 0; saw_done = 0; abort_seen = 0; cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (gnt == 4'b1000) break;
         if (tick) ticks++;
         if (done) saw_done = 1;
         if (req == 4'b1000 && gnt == 0 && !abort_seen) begin
            abort_seen = 1;
            chk("abort_cnt", 32'(tick_cnt), 32'h0);
         end
         if (ticks == 3 && req == 4'b1010) req = 4'b1000;
      end
      chk("abort_ticks", 32'(ticks),      32'd3);
      chk("abort_done",  32'(saw_done),   32'h0);
      chk("abort_seen",  32'(abort_seen), 32'h1);
      chk("abort_next",  32'(gnt),        32'b1000);
      req = '0;

      // Reset mid-burst at tick_cnt 5, then a fresh grant
      do_reset();
      set_skip_all(0);
      req = 4'b0100;
      cyc = 0; hit = 0;
      while (cyc < 60 && !hit) begin
         @(negedge clk);
         cyc++;
         hit = (tick_cnt == 4'd5);
      end
      chk("midrst_reach", 32'(hit), 32'h1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_gnt",  32'(gnt),      32'h0);
      chk("midrst_tick", 32'(tick),     32'h0);
      chk("midrst_cnt",  32'(tick_cnt), 32'h0);
      chk("midrst_busy", 32'(busy),     32'h0);
      chk("midrst_done", 32'(done),     32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_regrant", 32'(gnt), 32'b0100);
      req = '0;

      // Maximum skip: full-width compare means no tick within a short window
      do_reset();
      set_skip_all(0);
      skip[0 +: W] = '1;
      req = 4'b0001;
      ticks = 0;
      repeat (40) begin
         @(negedge clk);
         if (tick) ticks++;
      end
      chk("maxskip_ticks", 32'(ticks), 32'h0);
      chk("maxskip_busy",  32'(busy),  32'h1);
      req = '0;
      repeat (3) @(negedge clk);
      chk("maxskip_idle",  32'(busy),  32'h0);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) begin
            for (int i = 0; i < NREQ; i++) skip[i*W +: W] = W'($urandom_range(0, 3));
         end
      end
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
